// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateType;

    function automatic int stepsOf(input int width, input int bitsPerCycle);
        return width / bitsPerCycle;
    endfunction

    function automatic bit paramsLegal(input int width, input int bitsPerCycle, input int signedMode);
        return (width >= 2) && (bitsPerCycle >= 1) && (bitsPerCycle <= width) &&
               ((width % bitsPerCycle) == 0) && (signedMode == 0 || signedMode == 1);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple chain of N full-add cells; also reports the carry into its top bit.
module adder_slice #(
    parameter int N = 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : gCell
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout     = carry[N];
    assign c_msb_in = carry[N-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: one reused BITS_PER_CYCLE-wide slice walks the operands LSB first.
// Handshake: start is sampled only in IDLE/DONE; done is a one-cycle pulse with sum/carry_out/overflow valid.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SIGNED         = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = stepsOf(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = $clog2(STEPS + 1);

    if (!paramsLegal(WIDTH, BITS_PER_CYCLE, SIGNED)) begin : gBadParams
        $error("serial_adder: illegal WIDTH/BITS_PER_CYCLE/SIGNED combination");
    end

    stateType         state;
    logic [WIDTH-1:0] workA;
    logic [WIDTH-1:0] workB;
    logic [WIDTH-1:0] workSum;
    logic [WIDTH-1:0] nextSum;
    logic             runCarry;
    logic [CNT_W-1:0] stepCnt;
    logic [BPC-1:0]   sliceS;
    logic             sliceCout;
    logic             sliceCMsb;
    logic             lastStep;
    logic             overflowNext;

    adder_slice #(
        .N(BPC)
    ) uSlice (
        .a       (workA[BPC-1:0]),
        .b       (workB[BPC-1:0]),
        .cin     (runCarry),
        .s       (sliceS),
        .cout    (sliceCout),
        .c_msb_in(sliceCMsb)
    );

    // Slice result enters at the MSB end so the final step leaves the sum aligned.
    always_comb begin
        nextSum      = (workSum >> BPC) | (WIDTH'(sliceS) << (WIDTH - BPC));
        lastStep     = (stepCnt == CNT_W'(STEPS - 1));
        overflowNext = (SIGNED != 0) ? (sliceCout ^ sliceCMsb) : sliceCout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            workA     <= '0;
            workB     <= '0;
            workSum   <= '0;
            runCarry  <= 1'b0;
            stepCnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        workA    <= a;
                        workB    <= b;
                        runCarry <= carry_in;
                        workSum  <= '0;
                        stepCnt  <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    workA    <= workA >> BPC;
                    workB    <= workB >> BPC;
                    workSum  <= nextSum;
                    runCarry <= sliceCout;
                    stepCnt  <= stepCnt + CNT_W'(1);
                    // The final slice carries the MSB, so its carries define carry_out/overflow.
                    if (lastStep) begin
                        sum       <= nextSum;
                        carry_out <= sliceCout;
                        overflow  <= overflowNext;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder over six parameter sets sharing one clock.
`timescale 1ns/1ps
module tb_serial_adder;

    localparam int NCFG = 6;

    function automatic int cfgWidth(input int k);
        return (k < 3) ? 8 : 16;
    endfunction

    function automatic int cfgBpc(input int k);
        case (k)
            2:       return 4;
            4:       return 2;
            5:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int cfgSigned(input int k);
        case (k)
            0, 4, 5: return 1;
            default: return 0;
        endcase
    endfunction

    logic clk;
    int   checks = 0;
    int   passes = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int cfgIdx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h", cfgIdx, name, got, exp);
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int W     = cfgWidth(g);
        localparam int BPC   = cfgBpc(g);
        localparam int SG    = cfgSigned(g);
        localparam int STEPS = W / BPC;

        logic         rstN;
        logic         start;
        logic         cin;
        logic         busy;
        logic         done;
        logic         cout;
        logic         ovf;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic [W-1:0] prevSum;
        logic [W+1:0] exp_q[$];
        logic [W+1:0] e;
        logic         b2b      = 1'b0;
        logic         haveLast = 1'b0;
        logic         prevDone = 1'b0;
        logic         sumMoved = 1'b0;
        logic         drvDone  = 1'b0;
        int           busyLen  = 0;
        int           gap      = 0;

        serial_adder #(
            .WIDTH         (W),
            .BITS_PER_CYCLE(BPC),
            .SIGNED        (SG)
        ) dut (
            .clk      (clk),
            .rst_n    (rstN),
            .start    (start),
            .a        (a),
            .b        (b),
            .carry_in (cin),
            .busy     (busy),
            .done     (done),
            .sum      (sum),
            .carry_out(cout),
            .overflow (ovf)
        );

        // Waits until the DUT can accept, presents operands with start high, returns after the accepting edge.
        task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                             input logic ev, input logic ec, input logic [15:0] es);
            int n;
            n = 0;
            @(negedge clk);
            while (busy && n < 4 * STEPS + 8) begin
                @(negedge clk);
                n++;
            end
            if (busy) check("issue_timeout", g, 32'(busy), 32'd0);
            a     = va[W-1:0];
            b     = vb[W-1:0];
            cin   = vc;
            start = 1'b1;
            exp_q.push_back({ev, ec, es[W-1:0]});
            @(posedge clk);
            #1;
        endtask

        task automatic issueRand();
            logic [15:0] va;
            logic [15:0] vb;
            logic        vc;
            logic [W:0]  full;
            logic        v;
            va   = 16'($urandom_range(0, 65535));
            vb   = 16'($urandom_range(0, 65535));
            vc   = 1'($urandom_range(0, 1));
            full = {1'b0, va[W-1:0]} + {1'b0, vb[W-1:0]} + (W+1)'(vc);
            if (SG != 0) v = (va[W-1] == vb[W-1]) && (full[W-1] != va[W-1]);
            else         v = full[W];
            issue(va, vb, vc, v, full[W], 16'(full[W-1:0]));
        endtask

        initial begin
            rstN  = 1'b1;
            start = 1'b0;
            a     = '0;
            b     = '0;
            cin   = 1'b0;
            #2 rstN = 1'b0;
            repeat (3) @(negedge clk);
            @(posedge clk);
            #1 rstN = 1'b1;

            if (g == 0) begin
                issue(16'h3C, 16'h45, 1'b0, 1'b1, 1'b0, 16'h81); start = 1'b0;
                // start held during RUN with different operands must be ignored
                issue(16'h10, 16'h20, 1'b0, 1'b0, 1'b0, 16'h30);
                a   = ~a;
                b   = ~b;
                cin = 1'b1;
                repeat (3) @(posedge clk);
                #1 start = 1'b0;
                // abort after step 3 of 8; the pending result is withdrawn
                issue(16'h0F, 16'h01, 1'b0, 1'b0, 1'b0, 16'h10); start = 1'b0;
                repeat (3) @(posedge clk);
                #1 rstN = 1'b0;
                void'(exp_q.pop_back());
                @(negedge clk);
                @(posedge clk);
                #1 rstN = 1'b1;
                issue(16'h7F, 16'h01, 1'b0, 1'b1, 1'b0, 16'h80); start = 1'b0;
                issue(16'hFF, 16'hFF, 1'b1, 1'b0, 1'b1, 16'hFF); start = 1'b0;
                issue(16'h80, 16'h80, 1'b0, 1'b1, 1'b1, 16'h00); start = 1'b0;
            end else if (g == 1) begin
                issue(16'hFF, 16'h01, 1'b0, 1'b1, 1'b1, 16'h00); start = 1'b0;
                issue(16'h12, 16'h34, 1'b1, 1'b0, 1'b0, 16'h47); start = 1'b0;
                issue(16'h80, 16'h7F, 1'b1, 1'b1, 1'b1, 16'h00); start = 1'b0;
            end else if (g == 2) begin
                issue(16'hA5, 16'h5A, 1'b1, 1'b1, 1'b1, 16'h00); start = 1'b0;
                issue(16'h0F, 16'h01, 1'b0, 1'b0, 1'b0, 16'h10); start = 1'b0;
                issue(16'hF0, 16'h10, 1'b0, 1'b1, 1'b1, 16'h00); start = 1'b0;
                issue(16'h37, 16'h48, 1'b0, 1'b0, 1'b0, 16'h7F); start = 1'b0;
            end else begin
                b2b = 1'b1;
                repeat (200) issueRand();
                start = 1'b0;
            end

            for (int n = 0; n < 4 * STEPS + 8 && exp_q.size() != 0; n++) @(negedge clk);
            check("drain", g, 32'(exp_q.size()), 32'd0);
            drvDone = 1'b1;
        end

        always @(negedge clk) begin
            if (!rstN) begin
                check("reset_outputs", g, 32'({busy, done, cout, ovf, sum}), 32'd0);
                busyLen  = 0;
                gap      = 0;
                haveLast = 1'b0;
                sumMoved = 1'b0;
                prevDone = 1'b0;
                prevSum  = sum;
            end else begin
                gap++;
                if (busy) busyLen++;
                if (!done && sum !== prevSum) sumMoved = 1'b1;
                if (done) begin
                    check("done_expected", g, 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("result", g, 32'({ovf, cout, sum}), 32'(e));
                        check("busy_cycles", g, busyLen, STEPS);
                        check("sum_held", g, 32'(sumMoved), 32'd0);
                        check("done_pulse", g, 32'(prevDone), 32'd0);
                        if (b2b && haveLast) check("b2b_period", g, gap, STEPS + 1);
                        haveLast = b2b;
                    end
                    busyLen  = 0;
                    gap      = 0;
                    sumMoved = 1'b0;
                end
                prevDone = done;
                prevSum  = sum;
            end
        end
    end

    initial begin
        int n;
        logic allDone;
        n = 0;
        @(posedge clk);
        allDone = cfg[0].drvDone && cfg[1].drvDone && cfg[2].drvDone &&
                  cfg[3].drvDone && cfg[4].drvDone && cfg[5].drvDone;
        while (!allDone && n < 30000) begin
            @(posedge clk);
            n++;
            allDone = cfg[0].drvDone && cfg[1].drvDone && cfg[2].drvDone &&
                      cfg[3].drvDone && cfg[4].drvDone && cfg[5].drvDone;
        end
        if (!allDone) begin
            checks++;
            $display("FAIL finish_timeout: drivers not done after %0d cycles, required all done", n);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
